// File: rtl/fw_op_decoder_pkg.sv
// cms_pix28_package: shared op codes, status bit indices, array indices and ids
// used by the firmware command decoder and the IP test state machines.
// Ports: none (package).
package cms_pix28_package;

  typedef enum logic [3:0] {
    NOOP              = 4'h0,
    W_RST_FW          = 4'h1,
    W_CFG_STATIC_0    = 4'h2,
    R_CFG_STATIC_0    = 4'h3,
    W_CFG_STATIC_1    = 4'h4,
    R_CFG_STATIC_1    = 4'h5,
    W_CFG_ARRAY_0     = 4'h6,
    R_CFG_ARRAY_0     = 4'h7,
    W_CFG_ARRAY_1     = 4'h8,
    R_CFG_ARRAY_1     = 4'h9,
    W_CFG_ARRAY_2     = 4'hA,
    R_CFG_ARRAY_2     = 4'hB,
    R_DATA_ARRAY_0    = 4'hC,
    R_DATA_ARRAY_1    = 4'hD,
    W_STATUS_FW_CLEAR = 4'hE,
    W_EXECUTE         = 4'hF
  } op_code_t;

  typedef enum logic [2:0] {IDLE, DECODE, RD_WAIT, EXEC_BUSY, RST} state_t_op_dec;

  localparam int status_index_rst_fw        = 0;
  localparam int status_index_w_cfg_static_0 = 1;
  localparam int status_index_r_cfg_static_0 = 2;
  localparam int status_index_w_cfg_static_1 = 3;
  localparam int status_index_r_cfg_static_1 = 4;
  localparam int status_index_w_cfg_array_0 = 5;
  localparam int status_index_r_cfg_array_0 = 6;
  localparam int status_index_w_cfg_array_1 = 7;
  localparam int status_index_r_cfg_array_1 = 8;
  localparam int status_index_w_cfg_array_2 = 9;
  localparam int status_index_r_cfg_array_2 = 10;
  localparam int status_index_r_data_array_0 = 11;
  localparam int status_index_r_data_array_1 = 12;
  localparam int status_index_execute       = 13;
  localparam int status_index_test_done_0   = 14;  // bits 14..17, one per test number
  localparam int status_index_cmd_dropped   = 18;
  localparam int status_index_error         = 31;

  localparam logic [2:0] windex_cfg_0  = 3'd0;
  localparam logic [2:0] windex_cfg_1  = 3'd1;
  localparam logic [2:0] windex_cfg_2  = 3'd2;
  localparam logic [2:0] windex_data_0 = 3'd3;
  localparam logic [2:0] windex_data_1 = 3'd4;

  localparam logic [3:0] firmware_id_1 = 4'h1;
  localparam logic [3:0] firmware_id_2 = 4'h2;

  localparam logic [3:0] test_number_1 = 4'b0001;
  localparam logic [3:0] test_number_2 = 4'b0010;
  localparam logic [3:0] test_number_3 = 4'b0100;
  localparam logic [3:0] test_number_4 = 4'b1000;

  // Status bit raised when a storage/static command completes.
  function automatic logic [4:0] op_status_index(input op_code_t op);
    case (op)
      W_RST_FW:       op_status_index = 5'(status_index_rst_fw);
      W_CFG_STATIC_0: op_status_index = 5'(status_index_w_cfg_static_0);
      R_CFG_STATIC_0: op_status_index = 5'(status_index_r_cfg_static_0);
      W_CFG_STATIC_1: op_status_index = 5'(status_index_w_cfg_static_1);
      R_CFG_STATIC_1: op_status_index = 5'(status_index_r_cfg_static_1);
      W_CFG_ARRAY_0:  op_status_index = 5'(status_index_w_cfg_array_0);
      R_CFG_ARRAY_0:  op_status_index = 5'(status_index_r_cfg_array_0);
      W_CFG_ARRAY_1:  op_status_index = 5'(status_index_w_cfg_array_1);
      R_CFG_ARRAY_1:  op_status_index = 5'(status_index_r_cfg_array_1);
      W_CFG_ARRAY_2:  op_status_index = 5'(status_index_w_cfg_array_2);
      R_CFG_ARRAY_2:  op_status_index = 5'(status_index_r_cfg_array_2);
      R_DATA_ARRAY_0: op_status_index = 5'(status_index_r_data_array_0);
      R_DATA_ARRAY_1: op_status_index = 5'(status_index_r_data_array_1);
      W_EXECUTE:      op_status_index = 5'(status_index_execute);
      default:        op_status_index = 5'(status_index_error);
    endcase
  endfunction

  // Word-index counter (and rd_sel value) owned by an array op.
  function automatic logic [2:0] op_windex(input op_code_t op);
    case (op)
      W_CFG_ARRAY_0, R_CFG_ARRAY_0: op_windex = windex_cfg_0;
      W_CFG_ARRAY_1, R_CFG_ARRAY_1: op_windex = windex_cfg_1;
      W_CFG_ARRAY_2, R_CFG_ARRAY_2: op_windex = windex_cfg_2;
      R_DATA_ARRAY_0:               op_windex = windex_data_0;
      R_DATA_ARRAY_1:               op_windex = windex_data_1;
      default:                      op_windex = windex_cfg_0;
    endcase
  endfunction

endpackage

// File: rtl/fw_op_decoder_idx_counter.sv
// Modulo-N word-index counter: counts 0..N-1 then wraps to 0; clear has priority.
// Ports: i_clk, i_rst_n (async active-low), i_clr, i_inc, o_idx[W-1:0].
// Latency: o_idx reflects a clear/increment one cycle later; no backpressure.
module fw_op_idx_counter #(
  parameter int N = 217,
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= (r_idx == W'(N - 1)) ? '0 : r_idx + W'(1);
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/fw_op_decoder.sv
// Command front-end for one firmware IP: decodes {device_id, op_code, body} words,
// owns static cfg regs, array word indices, read-back handshake, sticky status.
// Ports: wr_* command in (wr_ready high only in IDLE), arr_wr_* / rd_* storage side,
// exec_*/test_done/fw_rst_req IP side, status out. Latency: 2 cycles word->effect.
module fw_op_decoder
  import cms_pix28_package::*;
#(
  parameter logic [3:0] FW_ID      = 4'h1,
  parameter int         CFG_WORDS  = 217,
  parameter int         DATA_WORDS = 32,
  parameter int         RD_TIMEOUT = 255,
  parameter int         RST_CYCLES = 4
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst_n,
  input  logic [31:0] wr_word,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [23:0] cfg_static_0,
  output logic [23:0] cfg_static_1,
  output logic [2:0]  arr_wr_en,
  output logic [7:0]  arr_wr_addr,
  output logic [23:0] arr_wr_data,
  output logic        rd_req,
  output logic [2:0]  rd_sel,
  output logic [7:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [23:0] rd_din,
  output logic [31:0] rd_word,
  output logic        rd_valid,
  output logic        exec_start,
  output logic [23:0] exec_cfg,
  input  logic [3:0]  test_done,
  output logic        fw_rst_req,
  output logic [31:0] status
);

  localparam logic [7:0] LP_TMO_LAST = 8'(RD_TIMEOUT - 1);
  localparam logic [7:0] LP_RST_LAST = 8'(RST_CYCLES - 1);

  state_t_op_dec r_state, w_state_nxt;

  logic [31:0] r_word, w_word_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [23:0] r_cfg0, w_cfg0_nxt, r_cfg1, w_cfg1_nxt;
  logic [2:0]  r_arr_en, w_arr_en_nxt;
  logic [7:0]  r_arr_addr, w_arr_addr_nxt;
  logic [23:0] r_arr_data, w_arr_data_nxt;
  logic        r_rd_req, w_rd_req_nxt;
  logic [2:0]  r_rd_sel, w_rd_sel_nxt;
  logic [7:0]  r_rd_addr, w_rd_addr_nxt;
  logic [31:0] r_rd_word, w_rd_word_nxt;
  logic        r_rd_valid, w_rd_valid_nxt;
  logic        r_exec_start, w_exec_start_nxt;
  logic [23:0] r_exec_cfg, w_exec_cfg_nxt;
  logic [3:0]  r_test_num, w_test_num_nxt;
  logic        r_fw_rst_req, w_fw_rst_req_nxt;
  logic [31:0] r_status, w_status_nxt;
  logic        r_wr_ready;

  logic [4:0]      w_idx_inc;
  logic            w_idx_clr;
  logic [4:0][7:0] w_idx;
  logic            w_go_rst, w_drop;

  op_code_t    w_op;
  logic [23:0] w_body;
  logic        w_id_ok, w_tn_onehot, w_busy_rst;
  logic [3:0]  w_test_num;
  logic [2:0]  w_win;
  logic [4:0]  w_sidx;

  // Five index counters: cfg arrays 0..2 then data arrays 0..1 (same order as rd_sel).
  for (genvar g = 0; g < 5; g++) begin : g_idx
    fw_op_idx_counter #(.N(g < 3 ? CFG_WORDS : DATA_WORDS), .W(8)) u_idx (
      .i_clk   (fw_axi_clk),
      .i_rst_n (fw_rst_n),
      .i_clr   (w_idx_clr),
      .i_inc   (w_idx_inc[g]),
      .o_idx   (w_idx[g])
    );
  end

  assign w_op        = op_code_t'(r_word[27:24]);
  assign w_body      = r_word[23:0];
  assign w_id_ok     = (r_word[31:28] == FW_ID) && (FW_ID != 4'h0);
  // IP1 and IP2 carry the test number in different body fields.
  assign w_test_num  = (FW_ID == firmware_id_2) ? w_body[15:12] : w_body[17:14];
  assign w_tn_onehot = (w_test_num != 4'b0) && ((w_test_num & (w_test_num - 4'd1)) == 4'b0);
  assign w_win       = op_windex(w_op);
  assign w_sidx      = op_status_index(w_op);
  // Only a reset command for this IP may interrupt a running test.
  assign w_busy_rst  = wr_valid && (wr_word[31:28] == FW_ID) && (FW_ID != 4'h0) &&
                       (wr_word[27:24] == W_RST_FW);

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_word_nxt       = r_word;
    w_cnt_nxt        = r_cnt;
    w_cfg0_nxt       = r_cfg0;
    w_cfg1_nxt       = r_cfg1;
    w_arr_en_nxt     = 3'b000;
    w_arr_addr_nxt   = r_arr_addr;
    w_arr_data_nxt   = r_arr_data;
    w_rd_req_nxt     = r_rd_req;
    w_rd_sel_nxt     = r_rd_sel;
    w_rd_addr_nxt    = r_rd_addr;
    w_rd_word_nxt    = r_rd_word;
    w_rd_valid_nxt   = 1'b0;
    w_exec_start_nxt = 1'b0;
    w_exec_cfg_nxt   = r_exec_cfg;
    w_test_num_nxt   = r_test_num;
    w_fw_rst_req_nxt = r_fw_rst_req;
    w_status_nxt     = r_status;
    w_idx_inc        = 5'b0;
    w_idx_clr        = 1'b0;
    w_go_rst         = 1'b0;
    w_drop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (wr_valid) begin
          w_word_nxt  = wr_word;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        w_drop      = wr_valid;
        w_state_nxt = IDLE;
        if (w_id_ok) begin
          case (w_op)
            W_RST_FW: w_go_rst = 1'b1;
            W_CFG_STATIC_0: begin
              w_cfg0_nxt           = w_body;
              w_status_nxt[w_sidx] = 1'b1;
            end
            W_CFG_STATIC_1: begin
              w_cfg1_nxt           = w_body;
              w_status_nxt[w_sidx] = 1'b1;
            end
            R_CFG_STATIC_0, R_CFG_STATIC_1: begin
              w_rd_word_nxt        = {FW_ID, w_op, (w_op == R_CFG_STATIC_0) ? r_cfg0 : r_cfg1};
              w_rd_valid_nxt       = 1'b1;
              w_status_nxt[w_sidx] = 1'b1;
            end
            W_CFG_ARRAY_0, W_CFG_ARRAY_1, W_CFG_ARRAY_2: begin
              w_arr_en_nxt         = 3'b001 << w_win;
              w_arr_addr_nxt       = w_idx[w_win];
              w_arr_data_nxt       = w_body;
              w_idx_inc[w_win]     = 1'b1;
              w_status_nxt[w_sidx] = 1'b1;
            end
            R_CFG_ARRAY_0, R_CFG_ARRAY_1, R_CFG_ARRAY_2, R_DATA_ARRAY_0, R_DATA_ARRAY_1: begin
              w_rd_req_nxt  = 1'b1;
              w_rd_sel_nxt  = w_win;
              w_rd_addr_nxt = w_idx[w_win];
              w_cnt_nxt     = 8'd0;
              w_state_nxt   = RD_WAIT;
            end
            W_STATUS_FW_CLEAR: w_status_nxt = 32'b0;
            W_EXECUTE: begin
              if (w_tn_onehot) begin
                w_exec_start_nxt                   = 1'b1;
                w_exec_cfg_nxt                     = w_body;
                w_test_num_nxt                     = w_test_num;
                w_status_nxt[status_index_execute] = 1'b1;
                w_state_nxt                        = EXEC_BUSY;
              end else begin
                w_status_nxt[status_index_error] = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        w_drop = wr_valid;
        if (rd_ack) begin
          w_rd_req_nxt         = 1'b0;
          w_rd_word_nxt        = {FW_ID, w_op, rd_din};
          w_rd_valid_nxt       = 1'b1;
          w_idx_inc[r_rd_sel]  = 1'b1;
          w_status_nxt[w_sidx] = 1'b1;
          w_state_nxt          = IDLE;
        end else if (r_cnt == LP_TMO_LAST) begin
          // Timeout leaves the index where it was so the read can be retried.
          w_rd_req_nxt                     = 1'b0;
          w_status_nxt[status_index_error] = 1'b1;
          w_state_nxt                      = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      EXEC_BUSY: begin
        // A reset in the same cycle as test_done wins; the done bit is not recorded.
        if (w_busy_rst) begin
          w_go_rst = 1'b1;
        end else begin
          w_drop = wr_valid;
          if ((test_done & r_test_num) != 4'b0) begin
            w_status_nxt[status_index_test_done_0 +: 4] =
              w_status_nxt[status_index_test_done_0 +: 4] | r_test_num;
            w_state_nxt = IDLE;
          end
        end
      end
      RST: begin
        if (r_cnt == LP_RST_LAST) begin
          w_fw_rst_req_nxt = 1'b0;
          w_status_nxt     = 32'b0;
          w_status_nxt[status_index_rst_fw] = 1'b1;
          w_state_nxt      = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_go_rst) begin
      w_state_nxt      = RST;
      w_fw_rst_req_nxt = 1'b1;
      w_cfg0_nxt       = 24'b0;
      w_cfg1_nxt       = 24'b0;
      w_status_nxt     = 32'b0;
      w_idx_clr        = 1'b1;
      w_cnt_nxt        = 8'd0;
    end else if (w_drop) begin
      w_status_nxt[status_index_cmd_dropped] = 1'b1;
    end
  end

  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      r_word       <= '0;
      r_cnt        <= '0;
      r_cfg0       <= '0;
      r_cfg1       <= '0;
      r_arr_en     <= '0;
      r_arr_addr   <= '0;
      r_arr_data   <= '0;
      r_rd_req     <= 1'b0;
      r_rd_sel     <= '0;
      r_rd_addr    <= '0;
      r_rd_word    <= '0;
      r_rd_valid   <= 1'b0;
      r_exec_start <= 1'b0;
      r_exec_cfg   <= '0;
      r_test_num   <= '0;
      r_fw_rst_req <= 1'b0;
      r_status     <= '0;
      r_wr_ready   <= 1'b0;
    end else begin
      r_word       <= w_word_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cfg0       <= w_cfg0_nxt;
      r_cfg1       <= w_cfg1_nxt;
      r_arr_en     <= w_arr_en_nxt;
      r_arr_addr   <= w_arr_addr_nxt;
      r_arr_data   <= w_arr_data_nxt;
      r_rd_req     <= w_rd_req_nxt;
      r_rd_sel     <= w_rd_sel_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
      r_rd_word    <= w_rd_word_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_exec_start <= w_exec_start_nxt;
      r_exec_cfg   <= w_exec_cfg_nxt;
      r_test_num   <= w_test_num_nxt;
      r_fw_rst_req <= w_fw_rst_req_nxt;
      r_status     <= w_status_nxt;
      // Registered so it stays low through reset and rises on the first clock after.
      r_wr_ready   <= (w_state_nxt == IDLE);
    end
  end

  assign wr_ready     = r_wr_ready;
  assign cfg_static_0 = r_cfg0;
  assign cfg_static_1 = r_cfg1;
  assign arr_wr_en    = r_arr_en;
  assign arr_wr_addr  = r_arr_addr;
  assign arr_wr_data  = r_arr_data;
  assign rd_req       = r_rd_req;
  assign rd_sel       = r_rd_sel;
  assign rd_addr      = r_rd_addr;
  assign rd_word      = r_rd_word;
  assign rd_valid     = r_rd_valid;
  assign exec_start   = r_exec_start;
  assign exec_cfg     = r_exec_cfg;
  assign fw_rst_req   = r_fw_rst_req;
  assign status       = r_status;

endmodule

// File: tb/tb_fw_op_decoder.sv
// Randomized bench for fw_op_decoder (FW_ID = 1) against a command-level model.
// Model holds cfg regs, per-array word indices and the expected status word.
// Latency: outputs sampled 1ns after each rising edge; inputs driven there too.
module tb_fw_op_decoder;

  localparam logic [3:0] OP_NOOP = 4'h0, OP_RST = 4'h1, OP_WS0 = 4'h2, OP_RS0 = 4'h3;
  localparam logic [3:0] OP_WS1  = 4'h4, OP_RS1 = 4'h5, OP_WA0 = 4'h6, OP_RA0 = 4'h7;
  localparam logic [3:0] OP_WA1  = 4'h8, OP_RA1 = 4'h9, OP_WA2 = 4'hA, OP_RA2 = 4'hB;
  localparam logic [3:0] OP_RD0  = 4'hC, OP_RD1 = 4'hD, OP_CLR = 4'hE, OP_EXEC = 4'hF;

  logic        clk = 1'b0;
  logic        fw_rst_n;
  logic [31:0] wr_word;
  logic        wr_valid;
  logic        wr_ready;
  logic [23:0] cfg_static_0, cfg_static_1;
  logic [2:0]  arr_wr_en;
  logic [7:0]  arr_wr_addr;
  logic [23:0] arr_wr_data;
  logic        rd_req;
  logic [2:0]  rd_sel;
  logic [7:0]  rd_addr;
  logic        rd_ack;
  logic [23:0] rd_din;
  logic [31:0] rd_word;
  logic        rd_valid;
  logic        exec_start;
  logic [23:0] exec_cfg;
  logic [3:0]  test_done;
  logic        fw_rst_req;
  logic [31:0] status;

  fw_op_decoder #(.FW_ID(4'h1)) dut (
    .fw_axi_clk(clk), .fw_rst_n(fw_rst_n),
    .wr_word(wr_word), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .cfg_static_0(cfg_static_0), .cfg_static_1(cfg_static_1),
    .arr_wr_en(arr_wr_en), .arr_wr_addr(arr_wr_addr), .arr_wr_data(arr_wr_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_din(rd_din), .rd_word(rd_word), .rd_valid(rd_valid),
    .exec_start(exec_start), .exec_cfg(exec_cfg), .test_done(test_done),
    .fw_rst_req(fw_rst_req), .status(status)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] m_cfg0, m_cfg1;
  int          m_idx [5];
  logic [31:0] m_status;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int arr_words(input int a);
    return (a < 3) ? 217 : 32;
  endfunction

  task automatic model_reset();
    m_cfg0 = '0;
    m_cfg1 = '0;
    for (int i = 0; i < 5; i++) m_idx[i] = 0;
    m_status = '0;
  endtask

  // Present one word when the decoder is ready; returns after the decode edge.
  task automatic send(input logic [31:0] w);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("wr_ready_wait", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_word  = w;
    tick();
    wr_valid = 1'b0;
    tick();
  endtask

  task automatic do_op(input logic [3:0] dev, input logic [3:0] op, input logic [23:0] body,
                       input int dly);
    int          a;
    logic [23:0] din;
    send({dev, op, body});
    if (dev != 4'h1) begin
      chk("foreign_en", 32'(arr_wr_en), 32'd0);
      chk("foreign_rv", 32'(rd_valid), 32'd0);
      chk("foreign_rq", 32'(rd_req), 32'd0);
      chk("foreign_st", status, m_status);
      return;
    end
    case (op)
      OP_WS0: begin m_cfg0 = body; chk("cfg0", 32'(cfg_static_0), 32'(m_cfg0)); end
      OP_WS1: begin m_cfg1 = body; chk("cfg1", 32'(cfg_static_1), 32'(m_cfg1)); end
      OP_RS0, OP_RS1: begin
        chk("rs_valid", 32'(rd_valid), 32'd1);
        chk("rs_word", rd_word, {4'h1, op, (op == OP_RS0) ? m_cfg0 : m_cfg1});
      end
      OP_WA0, OP_WA1, OP_WA2: begin
        a = (int'(op) - 6) / 2;
        chk("wa_en", 32'(arr_wr_en), 32'(1 << a));
        chk("wa_addr", 32'(arr_wr_addr), 32'(m_idx[a]));
        chk("wa_data", 32'(arr_wr_data), 32'(body));
        m_idx[a] = (m_idx[a] + 1) % arr_words(a);
      end
      OP_RA0, OP_RA1, OP_RA2, OP_RD0, OP_RD1: begin
        a = (op < OP_RD0) ? (int'(op) - 7) / 2 : int'(op) - 9;
        chk("rd_req_up", 32'(rd_req), 32'd1);
        chk("rd_sel", 32'(rd_sel), 32'(a));
        chk("rd_addr", 32'(rd_addr), 32'(m_idx[a]));
        repeat (dly) tick();
        chk("rd_req_hold", 32'(rd_req), 32'd1);
        din    = 24'($urandom);
        rd_din = din;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_word", rd_word, {4'h1, op, din});
        chk("rd_req_down", 32'(rd_req), 32'd0);
        m_idx[a] = (m_idx[a] + 1) % arr_words(a);
      end
      OP_CLR: m_status = '0;
      default: ;
    endcase
    if (op >= OP_RST && op <= OP_RD1) m_status[int'(op) - 1] = 1'b1;
    chk("status", status, m_status);
    tick();
    chk("pulse_en_low", 32'(arr_wr_en), 32'd0);
    chk("pulse_rv_low", 32'(rd_valid), 32'd0);
  endtask

  // Run one accepted test k; optionally a stray test_done and a dropped write first.
  task automatic do_exec(input int k, input logic [3:0] td_extra, input bit busy_write);
    logic [23:0] body;
    body        = 24'($urandom);
    body[17:14] = 4'b0001 << k;
    send({4'h1, OP_EXEC, body});
    m_status[13] = 1'b1;
    chk("exec_start", 32'(exec_start), 32'd1);
    chk("exec_cfg", 32'(exec_cfg), 32'(body));
    chk("exec_rdy", 32'(wr_ready), 32'd0);
    chk("exec_st", status, m_status);
    tick();
    chk("exec_start_low", 32'(exec_start), 32'd0);
    if (td_extra != 4'h0) begin
      test_done = td_extra;
      tick();
      test_done = 4'h0;
      chk("stray_done_st", status, m_status);
      chk("stray_done_rdy", 32'(wr_ready), 32'd0);
    end
    if (busy_write) begin
      wr_valid = 1'b1;
      wr_word  = {4'h1, OP_WS0, 24'h5A5A5A};
      tick();
      wr_valid = 1'b0;
      m_status[18] = 1'b1;
      chk("busy_drop_st", status, m_status);
      chk("busy_drop_cfg", 32'(cfg_static_0), 32'(m_cfg0));
    end
    test_done = 4'b0001 << k;
    tick();
    test_done = 4'h0;
    m_status[14 + k] = 1'b1;
    chk("done_st", status, m_status);
    chk("done_rdy", 32'(wr_ready), 32'd1);
  endtask

  task automatic check_rst_pulse();
    int n = 0;
    while (fw_rst_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("rst_width", 32'(n), 32'd4);
    model_reset();
    m_status = 32'h1;
    chk("rst_status", status, 32'h1);
    chk("rst_cfg0", 32'(cfg_static_0), 32'd0);
    chk("rst_cfg1", 32'(cfg_static_1), 32'd0);
  endtask

  initial begin
    int          n;
    int          r;
    logic [3:0]  op, dev, td;
    logic [23:0] body;

    fw_rst_n  = 1'b1;
    wr_word   = '0;
    wr_valid  = 1'b0;
    rd_ack    = 1'b0;
    rd_din    = '0;
    test_done = '0;
    model_reset();
    #2 fw_rst_n = 1'b0;
    #1;
    chk("rst_st", status, 32'h0);
    chk("rst_rdy", 32'(wr_ready), 32'd0);
    chk("rst_rq", 32'(rd_req), 32'd0);
    chk("rst_fwrq", 32'(fw_rst_req), 32'd0);
    repeat (2) tick();
    fw_rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", 32'(wr_ready), 32'd1);

    // Static register write then read-back.
    do_op(4'h1, OP_WS0, 24'hABCDEF, 0);
    chk("t1_cfg0", 32'(cfg_static_0), 32'h00ABCDEF);
    do_op(4'h1, OP_RS0, 24'h000000, 0);
    chk("t1_word", rd_word, 32'h13ABCDEF);
    chk("t1_status", status, 32'h6);

    // 218 writes to cfg array 1: index runs through the wrap.
    for (int i = 0; i < 218; i++) begin
      body = 24'($urandom);
      send({4'h1, OP_WA1, body});
      chk("t2_en", 32'(arr_wr_en), 32'b010);
      chk("t2_addr", 32'(arr_wr_addr), 32'(i % 217));
      chk("t2_data", 32'(arr_wr_data), 32'(body));
    end
    m_idx[1]    = 218 % 217;
    m_status[7] = 1'b1;
    chk("t2_bit7", 32'(status[7]), 32'd1);

    // Data array read with late ack, then a read that times out.
    do_op(4'h1, OP_RD0, 24'h0, 3);
    send({4'h1, OP_RD0, 24'h0});
    n = 0;
    while (rd_req === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 32'(n), 32'd255);
    m_status[31] = 1'b1;
    chk("tmo_status", status, m_status);
    do_op(4'h1, OP_RD0, 24'h0, 0);

    // Execute: test 2 with a stray test 1 done; then a non-one-hot test number.
    do_exec(1, 4'h1, 1'b0);
    body = 24'h0;
    body[17:14] = 4'h3;
    send({4'h1, OP_EXEC, body});
    m_status[31] = 1'b1;
    chk("exec_bad_start", 32'(exec_start), 32'd0);
    chk("exec_bad_st", status, m_status);
    chk("exec_bad_rdy", 32'(wr_ready), 32'd1);

    // Foreign device id, write while busy.
    do_op(4'h2, OP_WS0, 24'h123456, 0);
    chk("foreign_cfg0", 32'(cfg_static_0), 32'(m_cfg0));
    do_exec(2, 4'h0, 1'b1);

    // Randomized command mix.
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 19);
      if (r < 2) begin
        n  = $urandom_range(0, 3);
        td = 4'($urandom_range(0, 15)) & ~(4'b0001 << n);
        do_exec(n, td, 1'($urandom_range(0, 1)));
      end else begin
        op = 4'($urandom_range(0, 14));
        if (op == OP_RST) op = OP_NOOP;
        dev = 4'h1;
        if ($urandom_range(0, 9) == 0) begin
          dev = 4'($urandom_range(0, 15));
          if (dev == 4'h1) dev = 4'h0;
        end
        do_op(dev, op, 24'($urandom), $urandom_range(0, 4));
      end
    end

    // Reset command arriving with the matching test_done: reset wins.
    body        = 24'h0;
    body[17:14] = 4'b0001;
    send({4'h1, OP_EXEC, body});
    chk("t6_start", 32'(exec_start), 32'd1);
    wr_valid  = 1'b1;
    wr_word   = {4'h1, OP_RST, 24'h0};
    test_done = 4'b0001;
    tick();
    wr_valid  = 1'b0;
    test_done = 4'h0;
    chk("t6_rstreq", 32'(fw_rst_req), 32'd1);
    chk("t6_st_clr", status, 32'h0);
    check_rst_pulse();

    // Reset command from idle, then array indices restart at 0.
    do_op(4'h1, OP_WA2, 24'h00F00D, 0);
    send({4'h1, OP_RST, 24'h0});
    check_rst_pulse();
    do_op(4'h1, OP_WA2, 24'h0BEEF0, 0);

    // Async reset in the middle of a read wait.
    send({4'h1, OP_RA0, 24'h0});
    tick();
    #3 fw_rst_n = 1'b0;
    #1;
    chk("arst_rq", 32'(rd_req), 32'd0);
    chk("arst_st", status, 32'h0);
    chk("arst_rdy", 32'(wr_ready), 32'd0);
    chk("arst_cfg0", 32'(cfg_static_0), 32'd0);
    chk("arst_fwrq", 32'(fw_rst_req), 32'd0);
    @(posedge clk);
    #1 fw_rst_n = 1'b1;
    tick();
    chk("arst_rdy_up", 32'(wr_ready), 32'd1);
    model_reset();
    do_op(4'h1, OP_RA0, 24'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
